// File: rtl/sensor_period.sv
// Wheel (fork) and crank period measurement from deglitched active-low sensors.
// Produces tick-based periods with valid strobes, stopped flags and a saturating revolution count.
module sensor_period #(
    parameter int TICK_DIV = 32,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 4096,
    parameter int REV_W    = 24
) (
    input  logic                clock,
    input  logic                nRst,
    input  logic                nFork_deglitch,
    input  logic                nCrank_deglitch,
    input  logic                clear_rev,
    output logic [PERIOD_W-1:0] fork_period,
    output logic                fork_valid,
    output logic                fork_stopped,
    output logic [PERIOD_W-1:0] crank_period,
    output logic                crank_valid,
    output logic                crank_stopped,
    output logic [REV_W-1:0]    rev_count
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST    = PRESC_W'(TICK_DIV - 1);
    localparam logic [PERIOD_W-1:0] TIMEOUT_COUNT = PERIOD_W'(TIMEOUT);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    logic [PRESC_W-1:0] prescalerReg;
    logic               tick;
    logic [1:0]         sensorIn;
    logic [REV_W-1:0]   revReg;

    assign tick     = (prescalerReg == PRESC_LAST);
    assign sensorIn = {nCrank_deglitch, nFork_deglitch};

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            prescalerReg <= '0;
        end else begin
            prescalerReg <= tick ? '0 : prescalerReg + 1'b1;
        end
    end

    // Channel 0 is the fork, channel 1 the crank; both share the tick.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gChannel
            logic                prevReg;
            logic                stateReg;
            logic [PERIOD_W-1:0] counterReg;
            logic [PERIOD_W-1:0] periodReg;
            logic                validReg;
            logic                stoppedReg;
            logic                edgeSeen;

            assign edgeSeen = !sensorIn[gi] && prevReg;

            always_ff @(posedge clock or negedge nRst) begin
                if (!nRst) begin
                    prevReg    <= 1'b1;
                    stateReg   <= STATE_IDLE;
                    counterReg <= '0;
                    periodReg  <= '0;
                    validReg   <= 1'b0;
                    stoppedReg <= 1'b1;
                end else begin
                    prevReg  <= sensorIn[gi];
                    validReg <= 1'b0;
                    case (stateReg)
                        STATE_IDLE: begin
                            counterReg <= '0;
                            if (edgeSeen) begin
                                stateReg <= STATE_RUN;
                            end
                        end
                        default: begin
                            // An edge beats both timeout and tick; the tick in that cycle is lost.
                            if (edgeSeen) begin
                                periodReg  <= counterReg;
                                validReg   <= 1'b1;
                                stoppedReg <= 1'b0;
                                counterReg <= '0;
                            end else if (counterReg == TIMEOUT_COUNT) begin
                                periodReg  <= '0;
                                stoppedReg <= 1'b1;
                                counterReg <= '0;
                                stateReg   <= STATE_IDLE;
                            end else if (tick) begin
                                counterReg <= counterReg + 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            revReg <= '0;
        end else if (clear_rev) begin
            revReg <= '0;
        end else if (gChannel[0].edgeSeen && (revReg != {REV_W{1'b1}})) begin
            revReg <= revReg + 1'b1;
        end
    end

    assign fork_period   = gChannel[0].periodReg;
    assign fork_valid    = gChannel[0].validReg;
    assign fork_stopped  = gChannel[0].stoppedReg;
    assign crank_period  = gChannel[1].periodReg;
    assign crank_valid   = gChannel[1].validReg;
    assign crank_stopped = gChannel[1].stoppedReg;
    assign rev_count     = revReg;

endmodule

// File: tb/tb_sensor_period.sv
// Bench for sensor_period: directed and random sensor waveforms against a timestamp-based model
// that derives periods and timeouts from edge cycle numbers with plain arithmetic.
module tb_sensor_period;

    localparam int TD   = 4;
    localparam int TO   = 120;
    localparam int PW   = 16;
    localparam int RW   = 4;
    localparam int RMAX = 15;

    logic          clock = 1'b0;
    logic          nRst  = 1'b0;
    logic          nFork = 1'b1;
    logic          nCrank = 1'b1;
    logic          clearRev = 1'b0;
    logic [PW-1:0] forkPeriod;
    logic          forkValid;
    logic          forkStopped;
    logic [PW-1:0] crankPeriod;
    logic          crankValid;
    logic          crankStopped;
    logic [RW-1:0] revCount;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = fork, 1 = crank
    int cyc;
    int armed[2];
    int k0[2];
    int mPeriod[2];
    int mValid[2];
    int mStopped[2];
    int mPrev[2];
    int mRev;

    sensor_period #(.TICK_DIV(TD), .PERIOD_W(PW), .TIMEOUT(TO), .REV_W(RW)) dut (
        .clock(clock),
        .nRst(nRst),
        .nFork_deglitch(nFork),
        .nCrank_deglitch(nCrank),
        .clear_rev(clearRev),
        .fork_period(forkPeriod),
        .fork_valid(forkValid),
        .fork_stopped(forkStopped),
        .crank_period(crankPeriod),
        .crank_valid(crankValid),
        .crank_stopped(crankStopped),
        .rev_count(revCount)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Ticks fall on cycles c (counted from reset release) with c % TD == TD-1.
    function automatic int ticksBetween(input int a, input int b);
        return b / TD - (a + 1) / TD;
    endfunction

    // First cycle at which a channel armed at cycle k reports stopped (TO ticks after k, plus one).
    function automatic int deadlineOf(input int k);
        return ((k + 1) / TD + TO) * TD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_fork_period"}, 32'(forkPeriod), 0);
        chk({tag, "_fork_valid"}, 32'(forkValid), 0);
        chk({tag, "_fork_stopped"}, 32'(forkStopped), 1);
        chk({tag, "_crank_period"}, 32'(crankPeriod), 0);
        chk({tag, "_crank_valid"}, 32'(crankValid), 0);
        chk({tag, "_crank_stopped"}, 32'(crankStopped), 1);
        chk({tag, "_rev_count"}, 32'(revCount), 0);
    endtask

    task automatic modelReset();
        cyc = 0;
        mRev = 0;
        for (int ch = 0; ch < 2; ch++) begin
            armed[ch] = 0; k0[ch] = 0; mPeriod[ch] = 0;
            mValid[ch] = 0; mStopped[ch] = 1; mPrev[ch] = 1;
        end
    endtask

    // One clock cycle: drive inputs, advance the model for this edge, compare everything.
    task automatic step(input logic f, input logic c, input logic clr);
        int inVal[2];
        int edgeHit[2];
        nFork = f; nCrank = c; clearRev = clr;
        @(posedge clock);
        #1;
        inVal[0] = int'(f); inVal[1] = int'(c);
        for (int ch = 0; ch < 2; ch++) begin
            edgeHit[ch] = (inVal[ch] == 0 && mPrev[ch] == 1) ? 1 : 0;
            mPrev[ch] = inVal[ch];
            mValid[ch] = 0;
            if (edgeHit[ch] == 1) begin
                if (armed[ch] == 1) begin
                    mPeriod[ch] = ticksBetween(k0[ch], cyc);
                    mValid[ch] = 1;
                    mStopped[ch] = 0;
                end
                armed[ch] = 1;
                k0[ch] = cyc;
            end else if (armed[ch] == 1 && cyc == deadlineOf(k0[ch])) begin
                armed[ch] = 0;
                mPeriod[ch] = 0;
                mStopped[ch] = 1;
            end
        end
        if (clr) mRev = 0;
        else if (edgeHit[0] == 1 && mRev < RMAX) mRev++;
        chk("fork_period", 32'(forkPeriod), mPeriod[0]);
        chk("fork_valid", 32'(forkValid), mValid[0]);
        chk("fork_stopped", 32'(forkStopped), mStopped[0]);
        chk("crank_period", 32'(crankPeriod), mPeriod[1]);
        chk("crank_valid", 32'(crankValid), mValid[1]);
        chk("crank_stopped", 32'(crankStopped), mStopped[1]);
        chk("rev_count", 32'(revCount), mRev);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
    endtask

    // Fork falls now, stays low a random 1..3 cycles, total spacing to next edge = gap.
    task automatic forkEdge(input int gap);
        int lowLen;
        lowLen = $urandom_range(1, 3);
        for (int i = 0; i < lowLen; i++) step(1'b0, 1'b1, 1'b0);
        idle(gap - lowLen);
    endtask

    initial begin
        logic rf;
        logic rc;
        modelReset();

        // Reset held with toggling inputs
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            nFork = 1'($urandom); nCrank = 1'($urandom); clearRev = 1'($urandom);
            @(posedge clock);
            #1;
            chkReset("in_reset");
        end
        @(negedge clock);
        nFork = 1'b1; nCrank = 1'b1; clearRev = 1'b0;
        nRst = 1'b1;
        modelReset();
        idle(1000);

        // Fork edges every 400 clocks
        idle($urandom_range(0, 3));
        for (int e = 0; e < 5; e++) forkEdge(400);

        // Timeout: 80-clock edges, then silence
        for (int e = 0; e < 3; e++) forkEdge(80);
        idle(TO * TD + 20);
        chk("stopped_after_timeout", 32'(forkStopped), 1);
        chk("period_after_timeout", 32'(forkPeriod), 0);
        forkEdge(80);
        forkEdge(80);

        // Edge exactly in the cycle the counter sits at TIMEOUT
        while (cyc < deadlineOf(k0[0])) step(1'b1, 1'b1, 1'b0);
        forkEdge(10);
        chk("period_at_timeout_edge", 32'(forkPeriod), TO);
        chk("running_at_timeout_edge", 32'(forkStopped), 0);
        // One cycle later the channel has already stopped; the edge only re-arms
        while (cyc < deadlineOf(k0[0]) + 1) step(1'b1, 1'b1, 1'b0);
        forkEdge(40);
        chk("rearm_only_stopped", 32'(forkStopped), 1);
        forkEdge(40);

        // Simultaneous fork/crank edges, 200 and 400 clocks apart
        for (int i = 0; i < 8; i++) begin
            step(1'b0, (i % 2 == 0) ? 1'b0 : 1'b1, 1'b0);
            idle(199);
        end

        // Back-to-back edges: periods of 0 or 1 tick
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            idle($urandom_range(1, 5));
        end

        // Saturation and clear
        step(1'b1, 1'b1, 1'b1);
        for (int e = 0; e < 20; e++) forkEdge($urandom_range(2, 8));
        chk("rev_saturated", 32'(revCount), RMAX);
        step(1'b0, 1'b1, 1'b1);
        chk("rev_clear_wins", 32'(revCount), 0);
        idle(3);
        forkEdge(6);
        chk("rev_after_clear", 32'(revCount), 1);

        // Random waveforms on both channels with occasional clears
        rf = 1'b1; rc = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) rf = ~rf;
            if ($urandom_range(0, 49) == 0) rc = ~rc;
            step(rf, rc, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end
        idle(5);

        // Reset 30 ticks into a running measurement
        forkEdge(20);
        forkEdge(120);
        @(posedge clock);
        #3;
        nRst = 1'b0;
        nFork = 1'b1; nCrank = 1'b1; clearRev = 1'b0;
        #1;
        chkReset("mid_reset");
        @(negedge clock);
        nRst = 1'b1;
        modelReset();
        forkEdge(150);
        chk("first_edge_after_reset_rearms", 32'(forkStopped), 1);
        forkEdge(150);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
